// File: rtl/commitment_verify_without_aux_pkg.sv
// Shared constants, state encoding and vector slice helpers for the party-commitment
// generator (prover side) and verifier (commitment_verify_without_aux).
package commitment_verify_without_aux_pkg;

   localparam int unsigned N_PARTIES  = 15;
   localparam int unsigned SEED_W     = 128;
   localparam int unsigned DIGEST_W   = 256;
   localparam int unsigned IDX_W      = 8;
   localparam int unsigned SEED_VEC_W = N_PARTIES * SEED_W;
   localparam int unsigned C_VEC_W    = N_PARTIES * DIGEST_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PARTIES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StHash,
      StAdv,
      StCompare,
      StFinish
   } state_e;

   // Party 0 sits in the most significant slot; out-of-range indices fold onto slot 0.
   function automatic logic [SEED_W-1:0] seed_slice(input logic [SEED_VEC_W-1:0] vec,
                                                    input logic [IDX_W-1:0]      idx);
      int unsigned slot;
      slot = (idx <= LAST_IDX) ? (N_PARTIES - 1 - 32'(idx)) : 0;
      return vec[slot*SEED_W +: SEED_W];
   endfunction

   function automatic logic [DIGEST_W-1:0] commit_slice(input logic [C_VEC_W-1:0] vec,
                                                        input logic [IDX_W-1:0]   idx);
      int unsigned slot;
      slot = (idx <= LAST_IDX) ? (N_PARTIES - 1 - 32'(idx)) : 0;
      return vec[slot*DIGEST_W +: DIGEST_W];
   endfunction

endpackage

// File: rtl/H_for_C1.sv
// Commitment hash core H(seed, salt, t, j, i). This model has a fixed 5-cycle latency and
// returns {t, j, i, seed repeated}; a new request needs start low for a cycle after done.
module H_for_C1
   import commitment_verify_without_aux_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SEED_W-1:0]   seed,
   input  logic [DIGEST_W-1:0] salt,
   input  logic [IDX_W-1:0]    t,
   input  logic [IDX_W-1:0]    j,
   input  logic [IDX_W-1:0]    i,
   output logic [DIGEST_W-1:0] digest,
   output logic                done
);

   logic [2:0]          r_cnt;
   logic                r_busy;
   logic                r_wait_low;
   logic                r_done;
   logic [DIGEST_W-1:0] r_digest;
   logic                w_unused_salt;

   assign w_unused_salt = ^salt;
   assign digest        = r_digest;
   assign done          = r_done;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_wait_low <= 1'b0;
         r_done     <= 1'b0;
         r_digest   <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_busy) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd4) begin
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
               r_wait_low <= 1'b1;
            end
         end else if (!start) begin
            r_wait_low <= 1'b0;
         end else if (!r_wait_low) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_digest <= {t, j, i, seed[DIGEST_W-3*IDX_W-SEED_W-1:0], seed};
         end
      end
   end

endmodule

// File: rtl/commitment_verify_without_aux.sv
// Verifier-side rebuild of one repetition's 15-entry party commitment vector: opened parties
// are re-hashed, the hidden party's commitment comes from the proof, then C is compared.
module commitment_verify_without_aux
   import commitment_verify_without_aux_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [SEED_VEC_W-1:0] seed,
   input  logic [DIGEST_W-1:0]   salt,
   input  logic [IDX_W-1:0]      t,
   input  logic [IDX_W-1:0]      j,
   input  logic [IDX_W-1:0]      unopened,
   input  logic [DIGEST_W-1:0]   c_unopened,
   input  logic [C_VEC_W-1:0]    c_expected,
   input  logic                  ver_start,
   output logic                  ver_end,
   output logic                  match,
   output logic                  err,
   output logic [C_VEC_W-1:0]    C
);

   state_e              r_state;
   state_e              w_state_d;
   logic [IDX_W-1:0]    r_idx;
   logic [DIGEST_W-1:0] r_c [N_PARTIES];
   logic                r_hash_start;
   logic                r_ver_end;
   logic                r_match;
   logic                r_err;

   logic [SEED_W-1:0]   w_seed_i;
   logic [DIGEST_W-1:0] w_hash_digest;
   logic                w_hash_done;
   logic                w_start_req;
   logic                w_bad_idx;
   logic                w_idx_hit;
   logic                w_last;
   logic [3:0]          w_slot;

   assign w_seed_i    = seed_slice(seed, r_idx);
   assign w_start_req = ver_start && !r_ver_end;
   assign w_bad_idx   = (unopened > LAST_IDX);
   assign w_idx_hit   = (r_idx == unopened);
   assign w_last      = (r_idx == LAST_IDX);
   assign w_slot      = r_idx[3:0];

   assign ver_end = r_ver_end;
   assign match   = r_match;
   assign err     = r_err;

   always_comb begin
      C = '0;
      for (int k = 0; k < N_PARTIES; k++) begin
         C[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W] = r_c[k];
      end
   end

   H_for_C1 u_hash (
      .clk    (clk),
      .reset  (reset),
      .start  (r_hash_start),
      .seed   (w_seed_i),
      .salt   (salt),
      .t      (t),
      .j      (j),
      .i      (r_idx),
      .digest (w_hash_digest),
      .done   (w_hash_done)
   );

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:    if (w_start_req) w_state_d = w_bad_idx ? StFinish : StCheck;
         StCheck:   w_state_d = w_idx_hit ? StAdv : StHash;
         StHash:    if (w_hash_done) w_state_d = StAdv;
         StAdv:     w_state_d = w_last ? StCompare : StCheck;
         StCompare: w_state_d = StFinish;
         StFinish:  if (!ver_start) w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_idx        <= '0;
         r_hash_start <= 1'b0;
         r_ver_end    <= 1'b0;
         r_match      <= 1'b0;
         r_err        <= 1'b0;
         for (int k = 0; k < N_PARTIES; k++) r_c[k] <= '0;
      end else begin
         r_state <= w_state_d;
         unique case (r_state)
            StIdle: begin
               if (w_start_req) begin
                  r_match <= 1'b0;
                  r_err   <= w_bad_idx;
                  if (!w_bad_idx) r_idx <= '0;
               end
            end
            StCheck: begin
               if (w_idx_hit) r_c[w_slot] <= c_unopened;
               else           r_hash_start <= 1'b1;
            end
            StHash: begin
               // start falls with the capture, so the core sees it low through ADV and CHECK
               if (w_hash_done) begin
                  r_c[w_slot]  <= w_hash_digest;
                  r_hash_start <= 1'b0;
               end
            end
            StAdv: begin
               if (!w_last) r_idx <= r_idx + 1'b1;
            end
            StCompare: r_match <= (C == c_expected);
            StFinish:  r_ver_end <= ver_start;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_commitment_verify_without_aux.sv
// Scoreboard bench for commitment_verify_without_aux: expectations queued at start, popped at ver_end.
module tb_commitment_verify_without_aux;
   import commitment_verify_without_aux_pkg::*;

   typedef struct {
      logic               match;
      logic               err;
      logic [C_VEC_W-1:0] c;
      int                 starts;
      logic [IDX_W-1:0]   skip;
   } exp_t;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [SEED_VEC_W-1:0] seed;
   logic [DIGEST_W-1:0]   salt;
   logic [IDX_W-1:0]      t;
   logic [IDX_W-1:0]      j;
   logic [IDX_W-1:0]      unopened;
   logic [DIGEST_W-1:0]   c_unopened;
   logic [C_VEC_W-1:0]    c_expected;
   logic                  ver_start;
   logic                  ver_end;
   logic                  match;
   logic                  err;
   logic [C_VEC_W-1:0]    C;

   exp_t                  sb[$];
   int                    n_cmp = 0;
   int                    n_bad = 0;
   int                    n_starts = 0;
   logic [IDX_W-1:0]      idx_log[$];
   logic                  mon_prev = 1'b0;
   logic [C_VEC_W-1:0]    last_c = '0;

   commitment_verify_without_aux dut (
      .clk        (clk),
      .reset      (reset),
      .seed       (seed),
      .salt       (salt),
      .t          (t),
      .j          (j),
      .unopened   (unopened),
      .c_unopened (c_unopened),
      .c_expected (c_expected),
      .ver_start  (ver_start),
      .ver_end    (ver_end),
      .match      (match),
      .err        (err),
      .C          (C)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dut.r_hash_start && !mon_prev) begin
         n_starts = n_starts + 1;
         idx_log.push_back(dut.r_idx);
      end
      mon_prev = dut.r_hash_start;
   end

   function automatic logic [DIGEST_W-1:0] stub_h(input logic [7:0] tt, input logic [7:0] jj,
                                                  input logic [7:0] ii,
                                                  input logic [SEED_W-1:0] sd);
      logic [2*SEED_W-1:0] rep;
      rep = {sd, sd};
      return {tt, jj, ii, rep[DIGEST_W-25:0]};
   endfunction

   function automatic logic [SEED_VEC_W-1:0] mk_seeds();
      logic [SEED_VEC_W-1:0] v;
      for (int k = 0; k < N_PARTIES; k++) v[(N_PARTIES-1-k)*SEED_W +: SEED_W] = SEED_W'(k + 1);
      return v;
   endfunction

   function automatic logic [C_VEC_W-1:0] build_c(input logic [SEED_VEC_W-1:0] sd,
                                                  input logic [7:0] tt, input logic [7:0] jj,
                                                  input logic [7:0] un,
                                                  input logic [DIGEST_W-1:0] cu);
      logic [C_VEC_W-1:0] v;
      for (int k = 0; k < N_PARTIES; k++) begin
         if (k == int'(un)) v[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W] = cu;
         else v[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W] =
            stub_h(tt, jj, 8'(k), sd[(N_PARTIES-1-k)*SEED_W +: SEED_W]);
      end
      return v;
   endfunction

   task automatic run_op(input string tag, input logic [SEED_VEC_W-1:0] sd,
                         input logic [7:0] tt, input logic [7:0] jj, input logic [7:0] un,
                         input logic [DIGEST_W-1:0] cu, input logic [C_VEC_W-1:0] ce,
                         input int hold);
      exp_t e;
      exp_t g;
      int   base_n;
      int   base_log;
      int   lat;
      int   p;
      bit   done;
      bit   seq_ok;
      seed = sd; t = tt; j = jj; unopened = un; c_unopened = cu; c_expected = ce;
      e.err  = (un > 8'd14);
      e.skip = un;
      if (e.err) begin
         e.match = 1'b0; e.c = last_c; e.starts = 0;
      end else begin
         e.c = build_c(sd, tt, jj, un, cu); e.match = (e.c == ce); e.starts = 14;
      end
      sb.push_back(e);
      base_n   = n_starts;
      base_log = idx_log.size();
      ver_start = 1'b1;
      lat = 0; done = 1'b0;
      while (!done && lat < 1000) begin
         @(negedge clk);
         lat++;
         done = (ver_end === 1'b1);
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s ver_end timeout: waited %0d cycles, required a rise", tag, lat);
         void'(sb.pop_front());
         ver_start = 1'b0;
         repeat (2) @(negedge clk);
         return;
      end
      g = sb.pop_front();
      n_cmp++;
      if (match !== g.match) begin
         n_bad++; $display("FAIL %s match: got %b, required %b", tag, match, g.match);
      end
      n_cmp++;
      if (err !== g.err) begin
         n_bad++; $display("FAIL %s err: got %b, required %b", tag, err, g.err);
      end
      n_cmp++;
      if (C !== g.c) begin
         p = 0;
         for (int k = N_PARTIES - 1; k >= 0; k--)
            if (C[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W] !== g.c[(N_PARTIES-1-k)*DIGEST_W +: DIGEST_W])
               p = k;
         n_bad++;
         $display("FAIL %s C party %0d: got %h, required %h", tag, p,
                  C[(N_PARTIES-1-p)*DIGEST_W +: DIGEST_W], g.c[(N_PARTIES-1-p)*DIGEST_W +: DIGEST_W]);
      end
      n_cmp++;
      if (n_starts - base_n !== g.starts) begin
         n_bad++;
         $display("FAIL %s hash starts: got %0d, required %0d", tag, n_starts - base_n, g.starts);
      end
      if (g.err) begin
         n_cmp++;
         if (lat !== 2) begin
            n_bad++; $display("FAIL %s err latency: got %0d, required 2", tag, lat);
         end
      end else begin
         seq_ok = (idx_log.size() - base_log == 14);
         p = base_log;
         for (int k = 0; k < N_PARTIES; k++) begin
            if (k != int'(g.skip)) begin
               if (p >= idx_log.size() || idx_log[p] !== 8'(k)) seq_ok = 1'b0;
               p++;
            end
         end
         n_cmp++;
         if (!seq_ok) begin
            n_bad++; $display("FAIL %s hash index sequence: got %0d entries, required 14 skipping %0d",
                              tag, idx_log.size() - base_log, g.skip);
         end
      end
      last_c = g.c;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         n_cmp++;
         if (ver_end !== 1'b1) begin
            n_bad++; $display("FAIL %s ver_end hold cycle %0d: got %b, required 1", tag, h, ver_end);
         end
      end
      if (hold > 0) begin
         n_cmp++;
         if (n_starts - base_n !== g.starts) begin
            n_bad++; $display("FAIL %s restart during hold: starts %0d, required %0d", tag,
                              n_starts - base_n, g.starts);
         end
      end
      ver_start = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ver_end !== 1'b0) begin
         n_bad++; $display("FAIL %s ver_end clear: got %b, required 0", tag, ver_end);
      end
      @(negedge clk);
   endtask

   task automatic check_cleared(input string tag);
      n_cmp++;
      if ({ver_end, match, err} !== 3'b000 || C !== '0 || dut.r_hash_start !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: got ver_end=%b match=%b err=%b C_zero=%b start=%b, required all 0",
                  tag, ver_end, match, err, (C == '0), dut.r_hash_start);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; ver_start = 1'b0; seed = '0; salt = '0; t = '0; j = '0;
      unopened = '0; c_unopened = '0; c_expected = '0;
      repeat (3) @(negedge clk);
      check_cleared("reset_state");
      reset = 1'b1;
      @(negedge clk);
      check_cleared("post_reset_idle");
   endtask

   task automatic test_match();
      logic [SEED_VEC_W-1:0] sd;
      logic [DIGEST_W-1:0]   cu;
      sd = mk_seeds();
      salt = {8{32'hA5A5_0F0F}};
      cu = stub_h(8'h21, 8'h07, 8'd3, SEED_W'(4));
      run_op("match_u3", sd, 8'h21, 8'h07, 8'd3, cu, build_c(sd, 8'h21, 8'h07, 8'd3, cu), 0);
   endtask

   task automatic test_mismatch();
      logic [SEED_VEC_W-1:0] sd;
      logic [DIGEST_W-1:0]   cu;
      logic [C_VEC_W-1:0]    ce;
      sd = mk_seeds();
      cu = stub_h(8'h21, 8'h07, 8'd3, SEED_W'(4));
      ce = build_c(sd, 8'h21, 8'h07, 8'd3, cu);
      ce[0] = ~ce[0];
      run_op("mismatch_p14", sd, 8'h21, 8'h07, 8'd3, cu, ce, 0);
      n_cmp++;
      if (C[DIGEST_W-1:0] !== stub_h(8'h21, 8'h07, 8'd14, SEED_W'(15))) begin
         n_bad++; $display("FAIL mismatch C[14]: got %h, required %h", C[DIGEST_W-1:0],
                           stub_h(8'h21, 8'h07, 8'd14, SEED_W'(15)));
      end
   endtask

   task automatic test_unopened_edges();
      logic [SEED_VEC_W-1:0] sd;
      logic [DIGEST_W-1:0]   cu;
      sd = mk_seeds();
      cu = {8{32'hDEAD_BEEF}};
      run_op("unopened0", sd, 8'h05, 8'h02, 8'd0, cu, build_c(sd, 8'h05, 8'h02, 8'd0, cu), 0);
      n_cmp++;
      if (C[C_VEC_W-1 -: DIGEST_W] !== cu) begin
         n_bad++; $display("FAIL unopened0 C[0]: got %h, required %h", C[C_VEC_W-1 -: DIGEST_W], cu);
      end
      cu = {8{32'h1234_5678}};
      run_op("unopened14", sd, 8'h06, 8'h03, 8'd14, cu, build_c(sd, 8'h06, 8'h03, 8'd14, cu), 0);
      n_cmp++;
      if (C[DIGEST_W-1:0] !== cu) begin
         n_bad++; $display("FAIL unopened14 C[14]: got %h, required %h", C[DIGEST_W-1:0], cu);
      end
   endtask

   task automatic test_out_of_range();
      run_op("unopened15", mk_seeds(), 8'h06, 8'h03, 8'd15, '0, '0, 0);
   endtask

   task automatic test_back_to_back_hold();
      logic [SEED_VEC_W-1:0] sd;
      logic [DIGEST_W-1:0]   cu;
      sd = mk_seeds();
      cu = {8{32'hCAFE_F00D}};
      run_op("hold20", sd, 8'h33, 8'h44, 8'd9, cu, build_c(sd, 8'h33, 8'h44, 8'd9, cu), 20);
   endtask

   task automatic test_reset_mid();
      logic [SEED_VEC_W-1:0] sd;
      logic [DIGEST_W-1:0]   cu;
      int cyc;
      sd = mk_seeds();
      cu = stub_h(8'h21, 8'h07, 8'd3, SEED_W'(4));
      seed = sd; t = 8'h21; j = 8'h07; unopened = 8'd3; c_unopened = cu;
      c_expected = build_c(sd, 8'h21, 8'h07, 8'd3, cu);
      ver_start = 1'b1;
      cyc = 0;
      while (!(dut.r_hash_start === 1'b1 && dut.r_idx === 8'd7) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc >= 1000) begin
         n_bad++; $display("FAIL reset_mid party7 hash: not reached in %0d cycles", cyc);
      end
      reset = 1'b0; ver_start = 1'b0;
      @(negedge clk);
      check_cleared("reset_mid_cleared");
      @(negedge clk);
      reset = 1'b1;
      last_c = '0;
      @(negedge clk);
      run_op("after_reset", sd, 8'h21, 8'h07, 8'd3, cu, c_expected, 0);
   endtask

   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_unopened_edges();
      test_out_of_range();
      test_back_to_back_hold();
      test_reset_mid();
      n_cmp++;
      if (sb.size() !== 0) begin
         n_bad++; $display("FAIL scoreboard drain: %0d left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/commitment_verify_without_aux.md
Name: commitment_verify_without_aux

Overview:
- Verifier-side counterpart of the prover's party-commitment generator for parties without aux data.
- For one parallel repetition (t), rebuilds the 15-entry commitment vector C[i] = H(seed_i, salt, t, j, i). Every opened party is hashed; the unopened party's commitment is taken from the proof.
- Compares the rebuilt vector against an expected vector and reports match/mismatch.
- Sits between the proof parser and the challenge-hash recomputation in the verification path.

Parameters:
- N_PARTIES, 15, number of MPC parties per repetition (index width 8).
- SEED_W, 128, per-party seed width.
- DIGEST_W, 256, commitment digest width.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-low reset.
- seed  input  1920  opened seeds; party 0 in bits [1919:1792], party 14 in bits [127:0]. The unopened party's slot is ignored.
- salt  input  256  proof salt.
- t  input  8  repetition index.
- j  input  8  auxiliary index, passed unchanged to the hash.
- unopened  input  8  index of the hidden party, legal range 0..14.
- c_unopened  input  256  commitment of the hidden party, taken from the proof.
- c_expected  input  3840  reference commitment vector, same packing as C.
- ver_start  input  1  level request.
- ver_end  output reg  1  done flag.
- match  output reg  1  1 if the rebuilt C equals c_expected.
- err  output reg  1  unopened index out of range.
- C  output  3840  rebuilt vector; party 0 in bits [3839:3584], party 14 in bits [255:0].

Behaviour:
- Reset (sampled at posedge clk while reset==0):
  - all C entries, index i, ver_end, match, err and the hash start are cleared to 0; state goes to IDLE.
  - Reset asserted mid-operation aborts immediately. Hash start drops the next edge. No partial result is flagged.
- Handshake:
  - In IDLE, ver_start==1 with ver_end==0 begins an operation.
  - ver_end rises for the result. It stays 1 while ver_start stays 1.
  - ver_end clears in the cycle after ver_start is seen low.
  - Inputs must stay stable from start until ver_end.
- State IDLE:
  - On start with unopened>14: go to FINISH with err=1, match=0. No hashing occurs.
  - Otherwise: clear i, match and err, and go to CHECK.
- State CHECK:
  - If i==unopened: write C[i]<=c_unopened and go to ADV. This costs 1 cycle and no hash.
  - Otherwise: go to HASH.
- State HASH:
  - Drive the hash core with seed_i, salt, t, j, i and hold its start at 1.
  - When its end pulse arrives: capture the digest into C[i], drop start to 0, go to ADV.
  - The hash core must see start low for at least 1 cycle between parties.
- State ADV:
  - If i==N_PARTIES-1: go to COMPARE.
  - Otherwise: i<=i+1 and go to CHECK.
- State COMPARE: match <= (C == c_expected), full 3840-bit compare, registered. Go to FINISH.
- State FINISH: ver_end<=1. Hold there until ver_start==0, then ver_end<=0 and go to IDLE.
- Latency from start to ver_end:
  - ordinary case: 14 hash latencies plus roughly 3*15+3 control cycles.
  - out-of-range case: 2 cycles.
- Boundary cases:
  - unopened==0 and unopened==14 are both legal.
  - Exactly 14 hashes are issued per operation. The hash index input always equals the party index i, including across the skipped slot.
- ver_start dropping before ver_end is a protocol violation. The block still completes, then returns to IDLE.
- C keeps its last value until the next operation or reset.

Decomposition:
- Shared package:
  - constants N_PARTIES, SEED_W, DIGEST_W, IDX_W=8;
  - state encoding IDLE/CHECK/HASH/ADV/COMPARE/FINISH;
  - the seed/commitment slice helpers, shared with the prover-side generator.
- One sub-module: the existing commitment hash core H_for_C1. It is instantiated unchanged, with the same port order and start/end handshake as on the prover side.

Test Plan:
- Bench setup: stub hash with 5-cycle latency returning {t,j,i,seed[127:0] repeated} as digest.
- Seeds 0x01..0x0F, unopened=3, c_unopened=stub(seed=0x04,i=3), c_expected=full stub vector -> match=1, err=0. Expect exactly 14 hash start pulses.
- Same stimulus with c_expected bit 0 of party 14 flipped -> match=0, ver_end=1. C[14] equals the stub value.
- unopened=0, then unopened=14 -> C[0] or C[14] equals c_unopened. Hash index sequence skips only that party.
- unopened=15 -> err=1, match=0, ver_end high 2 cycles after start, zero hash starts.
- reset low during party 7 hash, then a new start -> all outputs 0 after reset. The second run gives a correct result.
- ver_start held 20 cycles after ver_end -> ver_end stays 1, no restart. Drop ver_start -> ver_end=0 next cycle.
